// File: rtl/cache_line_arbiter_pkg.sv
// Shared types and defaults for the I/D cache-line arbiter onto the physical-memory port.

package cache_line_arbiter_pkg;

  localparam int unsigned LINE_W_DEF = 256;
  localparam int unsigned ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/cache_line_arbiter.sv
// Merges I-cache and D-cache line traffic onto one pmem port, one transaction at a time.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: D wins ties).

module cache_line_arbiter
  import cache_line_arbiter_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state_q;
  logic       d_wr_q;
  logic       d_req;
  logic       d_wins;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;
  assign d_wins = (last_grant_q == GRANT_I);
`else
  assign d_wins = 1'b1;
`endif

  // Operation type is latched at grant so pmem_read/pmem_write never follow the request lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      d_wr_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= GRANT_I;
`endif
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (d_req && (!i_read || d_wins)) begin
            state_q <= ARB_SERVE_D;
            d_wr_q  <= d_write;
          end else if (i_read) begin
            state_q <= ARB_SERVE_I;
          end
        end
        ARB_SERVE_I: begin
          if (pmem_resp) begin
            state_q <= ARB_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= GRANT_I;
`endif
          end
        end
        ARB_SERVE_D: begin
          if (pmem_resp) begin
            state_q <= ARB_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= GRANT_D;
`endif
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (state_q)
      ARB_SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_address;
        i_resp       = pmem_resp;
      end
      ARB_SERVE_D: begin
        pmem_write   = d_wr_q;
        pmem_read    = ~d_wr_q;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Bench for cache_line_arbiter: vector table plus hand-written tie, stray-resp and reset sequences.

module tb_cache_line_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_read = 1'b0;
  logic [31:0]  i_address = '0;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [31:0]  d_address = '0;
  logic [255:0] d_wdata = '0;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  cache_line_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         is_d;
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
    int unsigned  lat;
  } vec_t;

  typedef struct {
    logic         is_d;
    logic [255:0] data;
  } exp_t;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rd"}, pmem_read, 1'b0);
    check({name, "_wr"}, pmem_write, 1'b0);
    check({name, "_addr"}, pmem_address, '0);
    check({name, "_wdata"}, pmem_wdata, '0);
    check({name, "_resp"}, {i_resp, d_resp}, 2'b00);
  endtask

  task automatic wait_pmem_req(input string name);
    bit seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin
        seen = 1;
        break;
      end
    end
    check({name, "_grant_seen"}, seen, 1'b1);
  endtask

  // Scoreboard: every client resp must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (i_resp || d_resp)) begin
      exp_t e;
      check("resp_exclusive", i_resp & d_resp, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {i_resp, d_resp}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("resp_client", d_resp, e.is_d);
        check("resp_data", e.is_d ? d_rdata : i_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t         vecs[5];
  vec_t         t;
  logic [31:0]  w;
  logic [255:0] rd;
  bit           exp_grant[4];
  int           drop_after;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0060, 256'h0, {32{8'hA5}}, 4};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, {8{32'h1234_5678}}, 256'h0, 3};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_2000, 256'h0, {8{32'hDEAD_BEEF}}, 1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0340, {8{32'h0F0F_1E1E}}, 256'h0, 2};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFE0, 256'h0, {8{32'h5A5A_C3C3}}, 2};
`ifdef ARB_ROUND_ROBIN_EN
    exp_grant  = '{1'b1, 1'b0, 1'b1, 1'b0};
    drop_after = 4;
`else
    exp_grant  = '{1'b1, 1'b1, 1'b0, 1'b0};
    drop_after = 1;
`endif

    // Reset with requests asserted: everything must stay quiet.
    i_read = 1'b1; d_write = 1'b1; d_wdata = {8{32'hFFFF_0000}}; d_address = 32'h80;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check("reset_rdata", {i_rdata, d_rdata}, '0);
    i_read = 1'b0; d_write = 1'b0; d_wdata = '0; d_address = '0;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle_no_req", {pmem_read, pmem_write}, 2'b00);
    end

    for (int v = 0; v < 5; v++) begin
      t = vecs[v];
      @(posedge clk); #1;
      if (t.is_d) begin
        d_read = t.rd; d_write = t.wr; d_address = t.addr; d_wdata = t.wdata;
        i_address = $urandom;
      end else begin
        i_read = 1'b1; i_address = t.addr;
        d_address = $urandom; d_wdata = {8{$urandom}};
      end
      exp_q.push_back('{t.is_d, t.rdata});
      @(posedge clk); @(negedge clk);
      check("vec_pmem_read", pmem_read, t.is_d ? (t.rd & ~t.wr) : 1'b1);
      check("vec_pmem_write", pmem_write, t.is_d & t.wr);
      check("vec_pmem_addr", pmem_address, t.addr);
      check("vec_pmem_wdata", pmem_wdata, t.is_d ? t.wdata : 256'h0);
      for (int c = 1; c < t.lat; c++) begin
        @(negedge clk);
        check("vec_hold_addr", pmem_address, t.addr);
        check("vec_no_early_resp", {i_resp, d_resp}, 2'b00);
      end
      @(posedge clk); #1 pmem_resp = 1'b1; pmem_rdata = t.rdata;
      @(posedge clk); #1 pmem_resp = 1'b0; pmem_rdata = '0;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      @(negedge clk);
      check("vec_bubble", {pmem_read, pmem_write}, 2'b00);
      check("vec_resp_seen", exp_q.size(), 0);
    end

    // Tie: both clients held and re-asserted after each resp.
    @(posedge clk); #1;
    i_read = 1'b1; i_address = 32'h40; d_read = 1'b1; d_address = 32'h80;
    for (int k = 0; k < 4; k++) begin
      wait_pmem_req("tie");
      check("tie_grant", pmem_address == 32'h80, exp_grant[k]);
      w  = 32'hC0DE_0000 + k;
      rd = {8{w}};
      exp_q.push_back('{exp_grant[k], rd});
      @(posedge clk); #1 pmem_resp = 1'b1; pmem_rdata = rd;
      @(posedge clk); #1 pmem_resp = 1'b0; pmem_rdata = '0;
      if (k == drop_after) d_read = 1'b0;
      @(negedge clk);
      check("tie_bubble", {pmem_read, pmem_write}, 2'b00);
    end
    i_read = 1'b0; d_read = 1'b0;
    repeat (3) @(negedge clk);
    check("tie_all_served", exp_q.size(), 0);

    // Stray pmem_resp while idle must be ignored.
    @(posedge clk); #1 pmem_resp = 1'b1; pmem_rdata = {8{32'hBAD0_BAD0}};
    @(negedge clk);
    check("stray_no_resp", {i_resp, d_resp}, 2'b00);
    @(posedge clk); #1 pmem_resp = 1'b0; pmem_rdata = '0;
    @(negedge clk);
    check("stray_still_idle", {pmem_read, pmem_write}, 2'b00);

    // Reset pulse during SERVE_D, then the held writeback is served afresh.
    @(posedge clk); #1;
    d_write = 1'b1; d_address = 32'h400; d_wdata = {8{32'hAB12_CD34}};
    wait_pmem_req("rst_pre");
    check("rst_pre_write", pmem_write, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    @(negedge clk);
    check_all_zero("rst_hold");
    #2 rst_n = 1'b1;
    wait_pmem_req("rst_post");
    check("rst_post_write", pmem_write, 1'b1);
    check("rst_post_addr", pmem_address, 32'h400);
    check("rst_post_wdata", pmem_wdata, {8{32'hAB12_CD34}});
    exp_q.push_back('{1'b1, 256'h0});
    @(posedge clk); #1 pmem_resp = 1'b1;
    @(posedge clk); #1 pmem_resp = 1'b0; d_write = 1'b0;
    @(negedge clk);
    check("rst_post_bubble", {pmem_read, pmem_write}, 2'b00);
    check("rst_post_resp_seen", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
